// File: rtl/id_queue_sched_id_queue.sv
// id_queue: an ID-indexed queue of up to CAPACITY elements with per-ID
// FIFO order.
//
// Storage is kept compacted in insertion order: slot 0 is the oldest
// element. A lookup returns the lowest-indexed (oldest) slot whose ID
// matches. Popping it shifts every younger slot down by one. This keeps
// the per-ID order intact without any linked-list bookkeeping.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (empties queue)
//   inp_id_i/inp_data_i  push payload
//   inp_req_i/inp_gnt_o  push handshake; gnt is low only when the queue is full
//   exists_*             masked data-match query (any stored element)
//   oup_id_i             lookup ID
//   oup_pop_i            remove the matched element when oup_req_i is set
//   oup_req_i/oup_gnt_o  lookup handshake; always granted
//   oup_data_o           oldest element for oup_id_i; valid iff oup_data_valid_o
//   usage_o              number of stored elements
module id_queue #(
  parameter int unsigned ID_WIDTH = 1,
  parameter int unsigned CAPACITY = 8,
  parameter type         data_t   = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ID_WIDTH-1:0]           inp_id_i,
  input  data_t                         inp_data_i,
  input  logic                          inp_req_i,
  output logic                          inp_gnt_o,
  input  data_t                         exists_data_i,
  input  data_t                         exists_mask_i,
  input  logic                          exists_req_i,
  output logic                          exists_o,
  output logic                          exists_gnt_o,
  input  logic [ID_WIDTH-1:0]           oup_id_i,
  input  logic                          oup_pop_i,
  input  logic                          oup_req_i,
  output data_t                         oup_data_o,
  output logic                          oup_data_valid_o,
  output logic                          oup_gnt_o,
  output logic [$clog2(CAPACITY+1)-1:0] usage_o
);

  localparam int unsigned CntW = $clog2(CAPACITY + 1);

  typedef logic [ID_WIDTH-1:0] id_t;

  id_t             ids_q  [CAPACITY];
  id_t             ids_d  [CAPACITY];
  data_t           data_q [CAPACITY];
  data_t           data_d [CAPACITY];
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            hit;
  logic [CntW-1:0] hit_idx;
  logic            exists_hit;
  logic            do_pop, do_push;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    oup_data_o = data_q[0];
    exists_hit = 1'b0;
    for (int unsigned i = 0; i < CAPACITY; i++) begin
      if (CntW'(i) < cnt_q) begin
        if (!hit && ids_q[i] == oup_id_i) begin
          hit        = 1'b1;
          hit_idx    = CntW'(i);
          oup_data_o = data_q[i];
        end
        if (((data_q[i] ^ exists_data_i) & exists_mask_i) == '0) begin
          exists_hit = 1'b1;
        end
      end
    end
  end

  assign oup_data_valid_o = hit;
  assign oup_gnt_o        = oup_req_i;
  assign inp_gnt_o        = (cnt_q != CntW'(CAPACITY));
  assign exists_o         = exists_req_i && exists_hit;
  assign exists_gnt_o     = exists_req_i;
  assign usage_o          = cnt_q;

  assign do_pop  = oup_req_i && oup_pop_i && hit;
  assign do_push = inp_req_i && inp_gnt_o;

  always_comb begin
    ids_d  = ids_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (do_pop) begin
      for (int unsigned i = 0; i + 1 < CAPACITY; i++) begin
        if (CntW'(i) >= hit_idx) begin
          ids_d[i]  = ids_q[i+1];
          data_d[i] = data_q[i+1];
        end
      end
      cnt_d = cnt_q - CntW'(1);
    end
    // Append after any pop compaction so a same-cycle push lands at the new tail.
    if (do_push) begin
      for (int unsigned i = 0; i < CAPACITY; i++) begin
        if (CntW'(i) == cnt_d) begin
          ids_d[i]  = inp_id_i;
          data_d[i] = inp_data_i;
        end
      end
      cnt_d = cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < CAPACITY; i++) begin
        ids_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      ids_q  <= ids_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/id_queue_sched.sv
// id_queue_sched: shares one id_queue between N_INP push requesters and a
// single lookup/pop requester. The queue takes one operation per cycle.
// Pushers are arbitrated round-robin. Pushes normally win over the pop port,
// but after MAX_STREAK consecutive push grants with a pending lookup, pushes
// are held off for one cycle so that the lookup is served.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   inp_id_i            packed per-requester push IDs (requester i at slice i)
//   inp_data_i          packed per-requester push data
//   inp_valid_i         push requests
//   inp_ready_o         push accepted, one-hot or zero
//   oup_id_i            lookup ID
//   oup_pop_i           dequeue the found element when granted
//   oup_req_i           lookup request
//   oup_gnt_o           lookup served this cycle
//   oup_data_o          head element for oup_id_i, valid iff oup_data_valid_o
//   oup_data_valid_o    ID was present
//   usage_o             elements stored
//   full_o / empty_o    usage_o == CAPACITY / usage_o == 0
module id_queue_sched #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned N_INP      = 2,
  parameter int unsigned MAX_STREAK = 4,
  parameter type         data_t     = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_INP*ID_WIDTH-1:0]     inp_id_i,
  input  logic [N_INP*$bits(data_t)-1:0] inp_data_i,
  input  logic [N_INP-1:0]              inp_valid_i,
  output logic [N_INP-1:0]              inp_ready_o,
  input  logic [ID_WIDTH-1:0]           oup_id_i,
  input  logic                          oup_pop_i,
  input  logic                          oup_req_i,
  output logic                          oup_gnt_o,
  output data_t                         oup_data_o,
  output logic                          oup_data_valid_o,
  output logic [$clog2(CAPACITY+1)-1:0] usage_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned DW = $bits(data_t);
  localparam int unsigned UW = $clog2(CAPACITY + 1);
  localparam int unsigned RW = (N_INP > 1) ? $clog2(N_INP) : 1;
  localparam int unsigned SW = $clog2(MAX_STREAK + 1);

  typedef logic [ID_WIDTH-1:0] id_t;

  logic [RW-1:0] rr_q, rr_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [UW-1:0] usage_q, usage_d;

  logic          found;
  logic [RW-1:0] winner;
  id_t           push_id;
  data_t         push_data;
  logic          block_push, push_gnt, pop_gnt;

  logic          q_inp_gnt, q_exists, q_exists_gnt, q_oup_gnt, q_valid;
  data_t         q_data;
  logic [UW-1:0] q_usage;

  // Round-robin search: first pass covers rr_q..N_INP-1, second pass wraps
  // to 0..rr_q-1. Payload of the winner is captured on the way.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    push_id   = '0;
    push_data = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (!found && inp_valid_i[i] && RW'(i) >= rr_q) begin
        found     = 1'b1;
        winner    = RW'(i);
        push_id   = inp_id_i[i*ID_WIDTH +: ID_WIDTH];
        push_data = inp_data_i[i*DW +: DW];
      end
    end
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (!found && inp_valid_i[i] && RW'(i) < rr_q) begin
        found     = 1'b1;
        winner    = RW'(i);
        push_id   = inp_id_i[i*ID_WIDTH +: ID_WIDTH];
        push_data = inp_data_i[i*DW +: DW];
      end
    end
  end

  assign full_o     = (usage_q == UW'(CAPACITY));
  assign empty_o    = (usage_q == '0);
  assign usage_o    = usage_q;
  assign block_push = oup_req_i && (streak_q == SW'(MAX_STREAK));

  // Handshakes are qualified with rst_ni so that nothing completes while
  // the asynchronous reset is asserted.
  assign push_gnt = rst_ni && found && !full_o && !block_push;
  assign pop_gnt  = rst_ni && oup_req_i && !push_gnt;

  always_comb begin
    for (int unsigned i = 0; i < N_INP; i++) begin
      inp_ready_o[i] = push_gnt && (RW'(i) == winner);
    end
  end

  assign oup_gnt_o        = pop_gnt;
  assign oup_data_valid_o = pop_gnt && q_valid;
  assign oup_data_o       = q_data;

  always_comb begin
    rr_d = rr_q;
    if (push_gnt) begin
      rr_d = (winner == RW'(N_INP - 1)) ? '0 : winner + RW'(1);
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!oup_req_i || pop_gnt) begin
      streak_d = '0;
    end else if (push_gnt && streak_q != SW'(MAX_STREAK)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_comb begin
    usage_d = usage_q;
    if (push_gnt) begin
      usage_d = usage_q + UW'(1);
    end else if (pop_gnt && oup_pop_i && q_valid) begin
      usage_d = usage_q - UW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      streak_q <= '0;
      usage_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      streak_q <= streak_d;
      usage_q  <= usage_d;
    end
  end

  id_queue #(
    .ID_WIDTH (ID_WIDTH),
    .CAPACITY (CAPACITY),
    .data_t   (data_t)
  ) i_queue (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .inp_id_i         (push_id),
    .inp_data_i       (push_data),
    .inp_req_i        (push_gnt),
    .inp_gnt_o        (q_inp_gnt),
    .exists_data_i    ('0),
    .exists_mask_i    ('1),
    .exists_req_i     (1'b0),
    .exists_o         (q_exists),
    .exists_gnt_o     (q_exists_gnt),
    .oup_id_i         (oup_id_i),
    .oup_pop_i        (oup_pop_i),
    .oup_req_i        (pop_gnt),
    .oup_data_o       (q_data),
    .oup_data_valid_o (q_valid),
    .oup_gnt_o        (q_oup_gnt),
    .usage_o          (q_usage)
  );

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_ready_o));
  a_usage_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    q_usage == usage_q);
  a_push_accepted: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_gnt |-> q_inp_gnt);
  a_pop_served: assert property (@(posedge clk_i) disable iff (!rst_ni)
    q_oup_gnt == pop_gnt);
  a_exists_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !q_exists && !q_exists_gnt);

endmodule

// File: tb/tb_id_queue_sched.sv
// Directed bench for id_queue_sched with a scoreboard: stimulus pushes the
// expected push winner / lookup response into queues, and a monitor at each
// falling edge pops and compares whenever the DUT shows a handshake.
module tb_id_queue_sched;

  localparam int unsigned IW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned NI = 2;
  localparam int unsigned CAP = 8;
  localparam int unsigned UW = $clog2(CAP + 1);

  typedef struct {
    bit       valid;
    bit [7:0] data;
  } pop_exp_t;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NI*IW-1:0]  inp_id;
  logic [NI*DW-1:0]  inp_data;
  logic [NI-1:0]     inp_valid;
  logic [NI-1:0]     inp_ready;
  logic [IW-1:0]     oup_id;
  logic              oup_pop, oup_req, oup_gnt, oup_dv;
  logic [DW-1:0]     oup_data;
  logic [UW-1:0]     usage;
  logic              full, empty;

  int n_tests = 0;
  int n_fail  = 0;

  int       exp_push [$];
  pop_exp_t exp_pop  [$];

  always #5 clk = ~clk;

  id_queue_sched #(
    .ID_WIDTH   (IW),
    .CAPACITY   (CAP),
    .N_INP      (NI),
    .MAX_STREAK (4),
    .data_t     (logic [7:0])
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .inp_id_i         (inp_id),
    .inp_data_i       (inp_data),
    .inp_valid_i      (inp_valid),
    .inp_ready_o      (inp_ready),
    .oup_id_i         (oup_id),
    .oup_pop_i        (oup_pop),
    .oup_req_i        (oup_req),
    .oup_gnt_o        (oup_gnt),
    .oup_data_o       (oup_data),
    .oup_data_valid_o (oup_dv),
    .usage_o          (usage),
    .full_o           (full),
    .empty_o          (empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: consumes one scoreboard entry per observed handshake.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (inp_ready != '0) begin
        if (exp_push.size() == 0) begin
          chk("unexpected_push_grant", int'(inp_ready), 0);
        end else begin
          int w;
          w = exp_push.pop_front();
          chk("push_winner", int'(inp_ready), 1 << w);
        end
      end
      if (oup_gnt) begin
        if (exp_pop.size() == 0) begin
          chk("unexpected_pop_grant", 1, 0);
        end else begin
          pop_exp_t e;
          e = exp_pop.pop_front();
          chk("pop_data_valid", int'(oup_dv), int'(e.valid));
          if (e.valid) chk("pop_data", int'(oup_data), int'(e.data));
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inp_valid = '0;
    oup_req   = 1'b0;
    oup_pop   = 1'b0;
  endtask

  task automatic set_push(input int r, input bit v, input int id, input int d);
    inp_valid[r]        = v;
    inp_id[r*IW +: IW]  = IW'(id);
    inp_data[r*DW +: DW] = DW'(d);
  endtask

  task automatic pop_one(input int id, input bit v, input int d);
    pop_exp_t e;
    e.valid = v;
    e.data  = 8'(d);
    exp_pop.push_back(e);
    oup_req = 1'b1;
    oup_pop = 1'b1;
    oup_id  = IW'(id);
    cyc();
    idle();
  endtask

  task automatic push_one(input int r, input int id, input int d);
    set_push(r, 1'b1, id, d);
    exp_push.push_back(r);
    cyc();
    inp_valid[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, d1;
    int wtab [4];
    wtab = '{1, 0, 1, 0};
    inp_id = '0; inp_data = '0; oup_id = '0;
    idle();
    rst_ni = 1'b0;
    // Requests active during reset: nothing may complete.
    set_push(0, 1'b1, 1, 8'h99);
    oup_req = 1'b1; oup_id = 2'd3;
    #1;
    @(negedge clk);
    chk("rst_ready", int'(inp_ready), 0);
    chk("rst_gnt", int'(oup_gnt), 0);
    chk("rst_dv", int'(oup_dv), 0);
    chk("rst_usage", int'(usage), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle();
    @(negedge clk);
    chk("idle_ready", int'(inp_ready), 0);
    chk("idle_usage", int'(usage), 0);
    chk("idle_empty", int'(empty), 1);
    @(posedge clk); #1;

    // Lookup on an empty queue: granted, miss.
    pop_one(3, 1'b0, 0);

    // Push-then-pop ordering.
    push_one(0, 1, 8'h0A);
    push_one(1, 1, 8'h0B);
    push_one(0, 0, 8'h0C);
    @(negedge clk);
    chk("order_usage3", int'(usage), 3);
    chk("order_not_empty", int'(empty), 0);
    @(posedge clk); #1;
    pop_one(1, 1'b1, 8'h0A);
    pop_one(1, 1'b1, 8'h0B);
    pop_one(0, 1'b1, 8'h0C);
    @(negedge clk);
    chk("order_usage0", int'(usage), 0);
    chk("order_empty", int'(empty), 1);
    @(posedge clk); #1;

    // Round-robin: both pushers valid, rr_q starts at 1 here.
    d0 = 8'h10; d1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      set_push(0, 1'b1, 2, d0);
      set_push(1, 1'b1, 3, d1);
      exp_push.push_back(wtab[k]);
      cyc();
      if (wtab[k] == 0) d0++; else d1++;
    end
    idle();
    @(negedge clk);
    chk("rr_usage4", int'(usage), 4);
    @(posedge clk); #1;
    pop_one(2, 1'b1, 8'h10);
    pop_one(2, 1'b1, 8'h11);
    pop_one(3, 1'b1, 8'h20);
    pop_one(3, 1'b1, 8'h21);

    // Starvation guard: four push grants, then the lookup wins.
    d0 = 8'h40; d1 = 8'h30;
    oup_req = 1'b1; oup_pop = 1'b0; oup_id = 2'd0;
    for (int k = 0; k < 4; k++) begin
      set_push(0, 1'b1, 1, d0);
      set_push(1, 1'b1, 1, d1);
      exp_push.push_back(wtab[k]);
      @(negedge clk);
      chk("starve_no_pop", int'(oup_gnt), 0);
      @(posedge clk); #1;
      if (wtab[k] == 0) d0++; else d1++;
    end
    begin
      pop_exp_t e;
      e.valid = 1'b0; e.data = 8'h00;
      exp_pop.push_back(e);
    end
    @(negedge clk);
    chk("starve_blocked_ready", int'(inp_ready), 0);
    chk("starve_pop_gnt", int'(oup_gnt), 1);
    @(posedge clk); #1;
    set_push(1, 1'b1, 1, d1);
    exp_push.push_back(1);
    cyc();
    idle();
    @(negedge clk);
    chk("starve_usage5", int'(usage), 5);
    @(posedge clk); #1;

    // Fill to capacity.
    push_one(0, 0, 8'h50);
    push_one(0, 0, 8'h51);
    push_one(0, 0, 8'h52);
    @(negedge clk);
    chk("full_usage8", int'(usage), 8);
    chk("full_flag", int'(full), 1);
    @(posedge clk); #1;
    set_push(1, 1'b1, 2, 8'h60);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("full_stall_ready", int'(inp_ready), 0);
      @(posedge clk); #1;
    end
    begin
      pop_exp_t e;
      e.valid = 1'b1; e.data = 8'h50;
      exp_pop.push_back(e);
    end
    oup_req = 1'b1; oup_pop = 1'b1; oup_id = 2'd0;
    @(negedge clk);
    chk("full_pop_ready", int'(inp_ready), 0);
    @(posedge clk); #1;
    oup_req = 1'b0; oup_pop = 1'b0;
    exp_push.push_back(1);
    @(negedge clk);
    chk("full_after_pop_usage7", int'(usage), 7);
    @(posedge clk); #1;
    inp_valid = '0;
    @(negedge clk);
    chk("full_refill_usage8", int'(usage), 8);
    chk("full_refill_flag", int'(full), 1);
    @(posedge clk); #1;
    pop_one(0, 1'b1, 8'h51);
    pop_one(0, 1'b1, 8'h52);
    pop_one(2, 1'b1, 8'h60);
    @(negedge clk);
    chk("pre_reset_usage5", int'(usage), 5);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream with requests active.
    set_push(0, 1'b1, 3, 8'h70);
    oup_req = 1'b1; oup_pop = 1'b1; oup_id = 2'd1;
    #2;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(inp_ready), 0);
    chk("midrst_gnt", int'(oup_gnt), 0);
    chk("midrst_usage", int'(usage), 0);
    chk("midrst_empty", int'(empty), 1);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle();
    @(negedge clk);
    chk("postrst_usage", int'(usage), 0);
    @(posedge clk); #1;
    pop_one(1, 1'b0, 0);
    cyc();
    chk("push_scoreboard_drained", exp_push.size(), 0);
    chk("pop_scoreboard_drained", exp_pop.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
